// File: rtl/branch_target_buffer_pkg.sv
// Pipeline package shared by the IF-stage branch target buffer: jump encodings,
// 2-bit counter states and the layout of one BTB entry.
package branch_target_buffer_pkg;

    localparam int BTB_XLEN    = 32;
    localparam int BTB_INDEX_W = 5;
    localparam int BTB_TAG_W   = BTB_XLEN - BTB_INDEX_W - 2;

    typedef enum logic [1:0] {
        JUMP_NONE = 2'b00,
        JUMP_JAL  = 2'b01,
        JUMP_JALR = 2'b10
    } jump_kind_t;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic [BTB_TAG_W-1:0] tag;
        logic [BTB_XLEN-1:0]  target;
        logic [1:0]           ctr;
        logic                 is_jump;
    } btb_entry_t;

endpackage

// File: rtl/branch_target_buffer_sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module sat_counter2
    import branch_target_buffer_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != CTR_ST) begin
                ctr_next = ctr + 2'd1;
            end
        end else begin
            if (ctr != CTR_SNT) begin
                ctr_next = ctr - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating counters; lookup is
// combinational from the table, training comes from resolved EX outcomes.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int XLEN    = BTB_XLEN,
    parameter int INDEX_W = BTB_INDEX_W,
    parameter int TAG_W   = XLEN - INDEX_W - 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] pc,
    output logic            predict_taken,
    output logic [XLEN-1:0] predicted_target,
    input  logic            update_valid,
    input  logic [XLEN-1:0] update_pc,
    input  logic            update_branch,
    input  logic [1:0]      update_jump,
    input  logic            update_taken,
    input  logic [XLEN-1:0] update_target
);

    localparam int ENTRIES = 2 ** INDEX_W;

    // Entry layout comes from the package, so XLEN/INDEX_W must match its widths.
    btb_entry_t btb_table [ENTRIES];

    logic [INDEX_W-1:0] lookup_idx;
    logic [TAG_W-1:0]   lookup_tag;
    btb_entry_t         lookup_entry;
    logic               lookup_hit;

    logic [INDEX_W-1:0] upd_idx;
    logic [TAG_W-1:0]   upd_tag;
    btb_entry_t         upd_entry;
    logic               upd_hit;
    logic               upd_is_jump;
    logic               upd_eff_taken;
    logic               upd_en;
    logic [1:0]         upd_ctr_next;
    btb_entry_t         next_entry;
    logic               write_en;
    logic [3:0]         unused_low_bits;

    assign unused_low_bits = {pc[1:0], update_pc[1:0]};

    assign lookup_idx   = pc[INDEX_W+1:2];
    assign lookup_tag   = pc[XLEN-1:INDEX_W+2];
    assign lookup_entry = btb_table[lookup_idx];
    assign lookup_hit   = lookup_entry.valid && (lookup_entry.tag == lookup_tag);

    assign predict_taken    = lookup_hit && (lookup_entry.is_jump || lookup_entry.ctr[1]);
    assign predicted_target = predict_taken ? lookup_entry.target : pc + XLEN'(4);

    assign upd_idx       = update_pc[INDEX_W+1:2];
    assign upd_tag       = update_pc[XLEN-1:INDEX_W+2];
    assign upd_entry     = btb_table[upd_idx];
    assign upd_hit       = upd_entry.valid && (upd_entry.tag == upd_tag);
    assign upd_is_jump   = (update_jump != JUMP_NONE);
    assign upd_eff_taken = upd_is_jump || update_taken;
    assign upd_en        = update_valid && (update_branch || upd_is_jump);

    sat_counter2 u_sat_counter2 (
        .ctr      (upd_entry.ctr),
        .taken    (update_taken),
        .ctr_next (upd_ctr_next)
    );

    // Jumps win over the branch flag; a not-taken miss leaves the table alone.
    always_comb begin
        next_entry = upd_entry;
        write_en   = 1'b0;
        if (upd_en) begin
            if (upd_hit) begin
                write_en = 1'b1;
                if (upd_is_jump) begin
                    next_entry.target  = update_target;
                    next_entry.is_jump = 1'b1;
                    next_entry.ctr     = CTR_ST;
                end else begin
                    next_entry.ctr = upd_ctr_next;
                    if (update_taken) begin
                        next_entry.target = update_target;
                    end
                end
            end else if (upd_eff_taken) begin
                write_en           = 1'b1;
                next_entry.valid   = 1'b1;
                next_entry.tag     = upd_tag;
                next_entry.target  = update_target;
                next_entry.is_jump = upd_is_jump;
                next_entry.ctr     = upd_is_jump ? CTR_ST : CTR_WT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_table[i].valid   <= 1'b0;
                btb_table[i].ctr     <= CTR_WNT;
                btb_table[i].is_jump <= 1'b0;
            end
        end else if (write_en) begin
            btb_table[upd_idx] <= next_entry;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed literal checks plus a
// randomized run compared every cycle against a table-level behavioural model.
module tb_branch_target_buffer;

    localparam logic [1:0] J_NONE = 2'b00;
    localparam logic [1:0] J_JAL  = 2'b01;
    localparam logic [1:0] J_JALR = 2'b10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        predict_taken;
    logic [31:0] predicted_target;
    logic        update_valid = 1'b0;
    logic [31:0] update_pc = 32'h0;
    logic        update_branch = 1'b0;
    logic [1:0]  update_jump = 2'b00;
    logic        update_taken = 1'b0;
    logic [31:0] update_target = 32'h0;

    int checks = 0;
    int passes = 0;

    bit          model_ready = 1'b0;
    bit          m_valid  [32];
    int unsigned m_tag    [32];
    logic [31:0] m_target [32];
    int          m_ctr    [32];
    bit          m_jump   [32];

    always #5 clk = ~clk;

    branch_target_buffer dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .pc               (pc),
        .predict_taken    (predict_taken),
        .predicted_target (predicted_target),
        .update_valid     (update_valid),
        .update_pc        (update_pc),
        .update_branch    (update_branch),
        .update_jump      (update_jump),
        .update_taken     (update_taken),
        .update_target    (update_target)
    );

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % 32);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        return int'(a >> 7);
    endfunction

    // Reference table updated on each rising edge from the sampled inputs.
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                m_valid[i] = 1'b0;
                m_ctr[i]   = 1;
                m_jump[i]  = 1'b0;
            end
            model_ready = 1'b1;
        end else if (update_valid && (update_branch || update_jump != 2'b00)) begin
            int  i;
            bit  jmp;
            bit  tk;
            i   = idx_of(update_pc);
            jmp = (update_jump != 2'b00);
            tk  = jmp || update_taken;
            if (m_valid[i] && m_tag[i] == tag_of(update_pc)) begin
                if (jmp) begin
                    m_target[i] = update_target;
                    m_jump[i]   = 1'b1;
                    m_ctr[i]    = 3;
                end else if (tk) begin
                    m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_target[i] = update_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (tk) begin
                m_valid[i]  = 1'b1;
                m_tag[i]    = tag_of(update_pc);
                m_target[i] = update_target;
                m_jump[i]   = jmp;
                m_ctr[i]    = jmp ? 3 : 2;
            end
        end
    end

    task automatic checkOutput(input string name, input logic exp_taken, input logic [31:0] exp_target);
        checks++;
        if (predict_taken === exp_taken && predicted_target === exp_target) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: pc=%h got taken=%0b target=%h, expected taken=%0b target=%h",
                     name, pc, predict_taken, predicted_target, exp_taken, exp_target);
        end
    endtask

    // Continuous comparison against the model on every falling edge.
    always @(negedge clk) begin
        if (model_ready) begin
            int   i;
            logic tk;
            i  = idx_of(pc);
            tk = m_valid[i] && m_tag[i] == tag_of(pc) && (m_jump[i] || m_ctr[i] >= 2);
            checkOutput("model", tk, tk ? m_target[i] : pc + 32'd4);
        end
    end

    task automatic applyStimulus(input logic [31:0] p, input logic uv, input logic [31:0] upc,
                                 input logic ub, input logic [1:0] uj, input logic ut,
                                 input logic [31:0] utgt);
        pc            = p;
        update_valid  = uv;
        update_pc     = upc;
        update_branch = ub;
        update_jump   = uj;
        update_taken  = ut;
        update_target = utgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] p);
        applyStimulus(p, 1'b0, 32'h0, 1'b0, J_NONE, 1'b0, 32'h0);
    endtask

    task automatic branchUpdate(input logic [31:0] p, input logic ut);
        applyStimulus(p, 1'b1, 32'h100, 1'b1, J_NONE, ut, 32'h80);
        tick();
        idle(p);
        @(negedge clk);
    endtask

    initial begin
        idle(32'h100);
        tick();
        tick();
        reset_n = 1'b1;

        @(negedge clk);
        checkOutput("reset_lookup", 1'b0, 32'h104);

        tick();
        branchUpdate(32'h100, 1'b1);
        checkOutput("alloc_branch", 1'b1, 32'h80);

        tick(); branchUpdate(32'h100, 1'b0);
        checkOutput("ctr_10_to_01", 1'b0, 32'h104);
        tick(); branchUpdate(32'h100, 1'b0);
        checkOutput("ctr_01_to_00", 1'b0, 32'h104);
        tick(); branchUpdate(32'h100, 1'b1);
        checkOutput("ctr_00_to_01", 1'b0, 32'h104);
        for (int k = 0; k < 4; k++) begin
            tick(); branchUpdate(32'h100, 1'b1);
            checkOutput("ctr_climb", 1'b1, 32'h80);
        end
        tick(); branchUpdate(32'h100, 1'b0);
        checkOutput("ctr_11_to_10", 1'b1, 32'h80);

        tick();
        idle(32'h180);
        @(negedge clk);
        checkOutput("alias_miss", 1'b0, 32'h184);
        tick();
        applyStimulus(32'h180, 1'b1, 32'h180, 1'b0, J_JALR, 1'b0, 32'h2000);
        tick();
        idle(32'h180);
        @(negedge clk);
        checkOutput("jalr_alloc", 1'b1, 32'h2000);
        tick();
        idle(32'h100);
        @(negedge clk);
        checkOutput("alias_evicted", 1'b0, 32'h104);
        tick();
        applyStimulus(32'h180, 1'b1, 32'h180, 1'b1, J_JALR, 1'b0, 32'h3000);
        tick();
        idle(32'h180);
        @(negedge clk);
        checkOutput("jalr_retarget", 1'b1, 32'h3000);

        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        applyStimulus(32'h100, 1'b1, 32'h100, 1'b1, J_NONE, 1'b1, 32'h80);
        @(negedge clk);
        checkOutput("same_cycle_old", 1'b0, 32'h104);
        tick();
        idle(32'h100);
        @(negedge clk);
        checkOutput("same_cycle_new", 1'b1, 32'h80);

        tick();
        reset_n = 1'b0;
        applyStimulus(32'h100, 1'b1, 32'h200, 1'b0, J_JAL, 1'b1, 32'h400);
        tick();
        @(negedge clk);
        checkOutput("during_reset", 1'b0, 32'h104);
        tick();
        reset_n = 1'b1;
        idle(32'h200);
        @(negedge clk);
        checkOutput("reset_drops_update", 1'b0, 32'h204);
        tick();
        idle(32'hFFFF_FFFC);
        @(negedge clk);
        checkOutput("pc_wrap", 1'b0, 32'h0000_0000);

        for (int n = 0; n < 600; n++) begin
            logic [31:0] p;
            logic [31:0] upc;
            logic [1:0]  uj;
            tick();
            reset_n = ($urandom_range(0, 99) != 0);
            p   = {23'($urandom_range(0, 2)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            upc = {23'($urandom_range(0, 2)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            uj  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) != 0) uj = J_NONE;
            applyStimulus(p, 1'($urandom_range(0, 1)), upc, 1'($urandom_range(0, 1)), uj,
                          1'($urandom_range(0, 1)), $urandom());
        end
        tick();
        reset_n = 1'b1;
        idle(32'h0);
        @(negedge clk);
        @(negedge clk);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
